// File: rtl/nn_parameters_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nn_parameters : per-layer sizes, widths, image files, FSM state  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package nn_parameters;

  localparam int    IN_SIZE_0      = 128;
  localparam int    OUT_SIZE_0     = 64;
  localparam int    DATA_W_0       = 24;
  localparam int    WEIGHT_W_0     = 16;
  localparam int    OUT_W_0        = 40;
  localparam string WEIGHTS_FILE_0 = "";
  localparam string BIAS_FILE_0    = "";

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index width that stays legal for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_unit : signed multiply-accumulate with synchronous clear     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mac_unit #(
  parameter int A_W   = 24,
  parameter int B_W   = 16,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [A_W+B_W-1:0] w_prod;

  assign w_prod = i_a * i_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_acc <= '0;
    end else if (i_clr) begin
      o_acc <= '0;
    end else if (i_en) begin
      o_acc <= o_acc + {{(ACC_W-A_W-B_W){w_prod[A_W+B_W-1]}}, w_prod};
    end
  end

endmodule
`default_nettype wire

// File: rtl/dense_layer_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dense_layer_seq : sequential fully-connected layer, one MAC/cycle |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module dense_layer_seq
  import nn_parameters::*;
#(
  parameter int    IN_SIZE      = IN_SIZE_0,
  parameter int    OUT_SIZE     = OUT_SIZE_0,
  parameter int    DATA_W       = DATA_W_0,
  parameter int    WEIGHT_W     = WEIGHT_W_0,
  parameter int    OUT_W        = OUT_W_0,
  parameter int    RELU_EN      = 0,
  parameter string WEIGHTS_FILE = WEIGHTS_FILE_0,
  parameter string BIAS_FILE    = BIAS_FILE_0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_vector  [IN_SIZE],
  output logic                     busy,
  output logic                     done,
  output logic signed [OUT_W-1:0]  output_vector [OUT_SIZE]
);

  localparam int ACC_W  = DATA_W + WEIGHT_W + $clog2(IN_SIZE) + 1;
  localparam int SUM_W  = ACC_W + 1;
  localparam int I_W    = idx_w(IN_SIZE);
  localparam int O_W    = idx_w(OUT_SIZE);
  localparam int ADDR_W = idx_w(OUT_SIZE * IN_SIZE);

  logic signed [WEIGHT_W-1:0] weight_matrix [0:OUT_SIZE*IN_SIZE-1];
  logic signed [WEIGHT_W-1:0] bias_vector   [0:OUT_SIZE-1];

  state_t                    r_state;
  logic        [I_W-1:0]     r_i;
  logic        [O_W-1:0]     r_o;
  logic signed [DATA_W-1:0]  r_x [IN_SIZE];
  logic signed [ACC_W-1:0]   w_acc;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [OUT_W-1:0]   w_sat;
  logic signed [OUT_W-1:0]   w_act;
  logic        [ADDR_W-1:0]  w_addr;
  logic                      w_accept;
  logic                      w_clr;
  logic                      w_mac_en;
  logic signed [WEIGHT_W-1:0] w_bias;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_clr    = w_accept || (r_state == ST_STORE);
  assign w_mac_en = (r_state == ST_MAC);
  assign w_addr   = ADDR_W'(int'(r_o) * IN_SIZE + int'(r_i));
  assign w_bias   = bias_vector[r_o];

  mac_unit #(
    .A_W   (DATA_W),
    .B_W   (WEIGHT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_mac_en),
    .i_a   (r_x[r_i]),
    .i_b   (weight_matrix[w_addr]),
    .o_acc (w_acc)
  );

  assign w_sum = {w_acc[ACC_W-1], w_acc} +
                 {{(SUM_W-WEIGHT_W){w_bias[WEIGHT_W-1]}}, w_bias};

  generate
    if (OUT_W >= SUM_W) begin : g_sat_none
      assign w_sat = OUT_W'(w_sum);
    end else begin : g_sat_clip
      localparam logic signed [SUM_W-1:0] c_max =
        {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [SUM_W-1:0] c_min =
        {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      assign w_sat = (w_sum > c_max) ? {1'b0, {(OUT_W-1){1'b1}}} :
                     (w_sum < c_min) ? {1'b1, {(OUT_W-1){1'b0}}} :
                     w_sum[OUT_W-1:0];
    end
  endgenerate

  assign w_act = ((RELU_EN != 0) && w_sat[OUT_W-1]) ? '0 : w_sat;

  // Operand capture carries no reset; it is only read after an accepted start.
  always_ff @(posedge clk) begin
    if (w_accept) r_x <= input_vector;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_i     <= '0;
      r_o     <= '0;
      for (int k = 0; k < OUT_SIZE; k++) output_vector[k] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i     <= '0;
            r_o     <= '0;
            busy    <= 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_i <= r_i + 1'b1;
          if (r_i == I_W'(IN_SIZE - 1)) r_state <= ST_STORE;
        end
        ST_STORE: begin
          output_vector[r_o] <= w_act;
          r_i <= '0;
          if (r_o == O_W'(OUT_SIZE - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_o     <= r_o + 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
